// File: rtl/uart_cmd_pkg.sv
// Shared constants, frame codes and state encodings for the UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] SOF_CMD = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [7:0] STATUS_OK   = 8'h00;
    localparam logic [7:0] STATUS_CHK  = 8'h01;
    localparam logic [7:0] STATUS_CMD  = 8'h02;
    localparam logic [7:0] STATUS_LINE = 8'h03;
    localparam logic [7:0] STATUS_ADDR = 8'h04;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_STROBE,
        RX_WAIT,
        EXEC,
        TX_LOAD,
        TX_STROBE,
        TX_WAIT
    } state_e;

    typedef enum logic [1:0] {
        TXB_IDLE,
        TXB_LOAD,
        TXB_STROBE,
        TXB_WAIT
    } tx_phase_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_byte_tx.sv
// Single-byte transmit handshake towards CoreUART: wait txrdy, one-cycle wen low, wait txrdy drop.
module uart_byte_tx
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       done,
    input  logic       txrdy,
    output logic       wen,
    output logic [7:0] data_in
);

    tx_phase_e  phase_q, phase_d;
    logic [7:0] data_q, data_d;
    logic       wen_q, wen_d;
    logic [1:0] guard_q, guard_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= TXB_IDLE;
            data_q  <= 8'h00;
            wen_q   <= 1'b1;
            guard_q <= 2'd0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        guard_d = guard_q;
        done    = 1'b0;
        case (phase_q)
            TXB_IDLE: begin
                if (start) begin
                    data_d  = tx_byte;
                    phase_d = TXB_LOAD;
                end
            end
            TXB_LOAD: begin
                if (txrdy) phase_d = TXB_STROBE;
            end
            TXB_STROBE: begin
                guard_d = 2'd0;
                phase_d = TXB_WAIT;
            end
            TXB_WAIT: begin
                // Guard keeps a transmitter that never drops txrdy from stalling us.
                if (!txrdy || guard_q == 2'd3) begin
                    done    = 1'b1;
                    phase_d = TXB_IDLE;
                end else begin
                    guard_d = guard_q + 2'd1;
                end
            end
            default: phase_d = TXB_IDLE;
        endcase
        wen_d = (phase_d != TXB_STROBE);
    end

    assign wen     = wen_q;
    assign data_in = data_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes 5-byte command frames from CoreUART, executes register reads/writes and returns 5-byte responses.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxrdy,
    input  logic [7:0]            data_out,
    input  logic                  framing_err,
    input  logic                  parity_err,
    input  logic                  overflow,
    output logic                  oen,
    input  logic                  txrdy,
    output logic [7:0]            data_in,
    output logic                  wen,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [7:0]            frame_ok_cnt,
    output logic [7:0]            frame_err_cnt,
    output logic                  busy
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d, tx_idx_q, tx_idx_d;
    logic [7:0]      byte_q, byte_d, cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, chk_q, chk_d;
    logic            err_cap_q, err_cap_d, line_err_q, line_err_d, oen_q, oen_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]      ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
    logic [7:0]      rsp_q [5];
    logic [7:0]      rsp_d [5];
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      regs_d [NUM_REGS];
    logic [AW-1:0]   addr_idx;
    logic [7:0]      status, rdata, tx_byte;
    logic            tx_start, tx_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RX_IDLE;
            idx_q      <= 3'd0;
            tx_idx_q   <= 3'd0;
            byte_q     <= 8'h00;
            cmd_q      <= 8'h00;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            chk_q      <= 8'h00;
            err_cap_q  <= 1'b0;
            line_err_q <= 1'b0;
            oen_q      <= 1'b1;
            to_cnt_q   <= '0;
            ok_cnt_q   <= 8'h00;
            err_cnt_q  <= 8'h00;
            for (int i = 0; i < 5; i++) rsp_q[i] <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_idx_q   <= tx_idx_d;
            byte_q     <= byte_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            chk_q      <= chk_d;
            err_cap_q  <= err_cap_d;
            line_err_q <= line_err_d;
            oen_q      <= oen_d;
            to_cnt_q   <= to_cnt_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
            rsp_q      <= rsp_d;
            regs_q     <= regs_d;
        end
    end

    assign addr_idx = addr_q[AW-1:0];

    // Status priority: line error, checksum, unknown command, address range.
    always_comb begin
        if (line_err_q)                             status = STATUS_LINE;
        else if (chk_q != (cmd_q ^ addr_q ^ data_q)) status = STATUS_CHK;
        else if (cmd_q != CMD_WR && cmd_q != CMD_RD) status = STATUS_CMD;
        else if (32'(addr_q) >= NUM_REGS)           status = STATUS_ADDR;
        else                                        status = STATUS_OK;
        if (status != STATUS_OK)  rdata = 8'h00;
        else if (cmd_q == CMD_WR) rdata = data_q;
        else                      rdata = regs_q[addr_idx];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_idx_d   = tx_idx_q;
        byte_d     = byte_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        chk_d      = chk_q;
        err_cap_d  = err_cap_q;
        line_err_d = line_err_q;
        to_cnt_d   = to_cnt_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        rsp_d      = rsp_q;
        regs_d     = regs_q;
        tx_start   = 1'b0;

        if (idx_q != 3'd0 && overflow &&
            (state_q == RX_IDLE || state_q == RX_STROBE || state_q == RX_WAIT))
            line_err_d = 1'b1;

        case (state_q)
            RX_IDLE: begin
                // An expiring timeout takes precedence over a byte arriving in the same cycle.
                if (idx_q != 3'd0 && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    idx_d     = 3'd0;
                    to_cnt_d  = '0;
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    if (idx_q != 3'd0) to_cnt_d = to_cnt_q + 1'b1;
                    if (rxrdy)         state_d  = RX_STROBE;
                end
            end
            RX_STROBE: begin
                byte_d    = data_out;
                err_cap_d = framing_err | parity_err | overflow;
                to_cnt_d  = '0;
                state_d   = RX_WAIT;
            end
            RX_WAIT: begin
                if (!rxrdy) begin
                    state_d = RX_IDLE;
                    if (idx_q != 3'd0) line_err_d = line_err_d | err_cap_q;
                    case (idx_q)
                        3'd0: begin
                            if (byte_q == SOF_CMD) begin
                                idx_d      = 3'd1;
                                line_err_d = err_cap_q;
                            end
                        end
                        3'd1: begin cmd_d  = byte_q; idx_d = 3'd2; end
                        3'd2: begin addr_d = byte_q; idx_d = 3'd3; end
                        3'd3: begin data_d = byte_q; idx_d = 3'd4; end
                        default: begin chk_d = byte_q; state_d = EXEC; end
                    endcase
                end
            end
            EXEC: begin
                if (status == STATUS_OK && cmd_q == CMD_WR) regs_d[addr_idx] = data_q;
                rsp_d[0] = SOF_RSP;
                rsp_d[1] = status;
                rsp_d[2] = addr_q;
                rsp_d[3] = rdata;
                rsp_d[4] = status ^ addr_q ^ rdata;
                idx_d    = 3'd0;
                tx_idx_d = 3'd0;
                state_d  = TX_LOAD;
            end
            TX_LOAD: begin
                tx_start = 1'b1;
                state_d  = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    if (tx_idx_q == 3'd4) begin
                        state_d = RX_IDLE;
                        if (rsp_q[1] == STATUS_OK) ok_cnt_d  = sat_inc(ok_cnt_q);
                        else                       err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        state_d  = TX_LOAD;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        oen_d = (state_d != RX_STROBE);
    end

    always_comb begin
        case (tx_idx_q)
            3'd0:    tx_byte = rsp_q[0];
            3'd1:    tx_byte = rsp_q[1];
            3'd2:    tx_byte = rsp_q[2];
            3'd3:    tx_byte = rsp_q[3];
            default: tx_byte = rsp_q[4];
        endcase
    end

    uart_byte_tx u_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .tx_byte (tx_byte),
        .done    (tx_done),
        .txrdy   (txrdy),
        .wen     (wen),
        .data_in (data_in)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[8*gi +: 8] = regs_q[gi];
        end
    endgenerate

    assign oen           = oen_q;
    assign frame_ok_cnt  = ok_cnt_q;
    assign frame_err_cnt = err_cnt_q;
    assign busy          = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench: emulates CoreUART rx/tx handshakes and checks response frames, registers and counters.
module tb_uart_cmd_parser;

    localparam int NREG = 16;
    localparam int TOUT = 64;

    logic             clk, rst, rxrdy, framing_err, parity_err, overflow, txrdy;
    logic [7:0]       data_out, data_in, frame_ok_cnt, frame_err_cnt;
    logic             oen, wen, busy;
    logic [NREG*8-1:0] regs_flat;

    int checks   = 0;
    int failures = 0;
    logic [7:0] tx_q [$];

    uart_cmd_parser #(.NUM_REGS(NREG), .TIMEOUT_CYC(TOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxrdy         (rxrdy),
        .data_out      (data_out),
        .framing_err   (framing_err),
        .parity_err    (parity_err),
        .overflow      (overflow),
        .oen           (oen),
        .txrdy         (txrdy),
        .data_in       (data_in),
        .wen           (wen),
        .regs_flat     (regs_flat),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmit-side responder: captures each strobed byte, then drops txrdy for two cycles.
    initial begin
        txrdy = 1'b1;
        forever begin
            @(negedge clk);
            if (!wen) begin
                tx_q.push_back(data_in);
                $display("tx byte %0d = %02h", tx_q.size() - 1, data_in);
                txrdy = 1'b0;
                repeat (2) @(negedge clk);
                txrdy = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        data_out   = b;
        parity_err = pe;
        rxrdy      = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!oen) seen = 1'b1;
        end
        if (!seen) chk("oen_strobe_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("oen_one_cycle", 64'(oen), 64'd1);
        rxrdy      = 1'b0;
        parity_err = 1'b0;
        data_out   = 8'h00;
    endtask

    task automatic send_frame(input logic [39:0] f, input int pe_idx);
        for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8], (i == pe_idx));
    endtask

    task automatic expect_rsp(input string tag, input logic [39:0] exp);
        for (int i = 0; i < 400 && tx_q.size() < 5; i++) @(negedge clk);
        chk({tag, "_count"}, 64'(tx_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < tx_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 64'(tx_q[i]), 64'(exp[39-8*i -: 8]));
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        $display("response %s done, %0d bytes", tag, tx_q.size());
        tx_q.delete();
    endtask

    initial begin
        rst = 1'b0; rxrdy = 1'b0; data_out = 8'h00;
        framing_err = 1'b0; parity_err = 1'b0; overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oen", 64'(oen), 64'd1);
        chk("rst_wen", 64'(wen), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data_in", 64'(data_in), 64'h00);
        chk("rst_regs", 64'(regs_flat[63:0]), 64'h0);
        chk("rst_ok_cnt", 64'(frame_ok_cnt), 64'h00);
        chk("rst_err_cnt", 64'(frame_err_cnt), 64'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write reg3 then read it back.
        send_frame(40'hA5_01_03_C4_C6, -1);
        expect_rsp("wr3", 40'h5A_00_03_C4_C7);
        chk("reg3_written", 64'(regs_flat[31:24]), 64'hC4);
        send_frame(40'hA5_02_03_00_01, -1);
        expect_rsp("rd3", 40'h5A_00_03_C4_C7);
        chk("ok_cnt_2", 64'(frame_ok_cnt), 64'd2);

        send_frame(40'hA5_01_02_55_00, -1);
        expect_rsp("badchk", 40'h5A_01_02_00_03);
        chk("reg2_unchanged", 64'(regs_flat[23:16]), 64'h00);
        chk("err_cnt_1", 64'(frame_err_cnt), 64'd1);

        // Leading garbage must be dropped silently before the real frame.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (10) @(negedge clk);
        chk("resync_no_rsp", 64'(tx_q.size()), 64'd0);
        send_frame(40'hA5_02_20_00_22, -1);
        expect_rsp("badaddr", 40'h5A_04_20_00_24);
        chk("err_cnt_2", 64'(frame_err_cnt), 64'd2);

        send_frame(40'hA5_01_05_77_73, 2);
        expect_rsp("lineerr", 40'h5A_03_05_00_06);
        chk("reg5_not_written", 64'(regs_flat[47:40]), 64'h00);
        chk("err_cnt_3", 64'(frame_err_cnt), 64'd3);

        // Partial frame then silence long enough to expire the inter-byte timeout.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (TOUT / 2) @(negedge clk);
        chk("timeout_not_early", 64'(frame_err_cnt), 64'd3);
        repeat (TOUT / 2 + 4) @(negedge clk);
        chk("timeout_err_cnt", 64'(frame_err_cnt), 64'd4);
        chk("timeout_no_rsp", 64'(tx_q.size()), 64'd0);
        send_frame(40'hA5_01_07_3C_3A, -1);
        expect_rsp("after_to", 40'h5A_00_07_3C_3B);
        chk("reg7_written", 64'(regs_flat[63:56]), 64'h3C);
        chk("ok_cnt_3", 64'(frame_ok_cnt), 64'd3);

        // Reset while the third response byte is still pending.
        send_frame(40'hA5_02_07_00_05, -1);
        for (int i = 0; i < 400 && tx_q.size() < 2; i++) @(negedge clk);
        chk("pre_reset_bytes", 64'(tx_q.size()), 64'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(wen), 64'd1);
        chk("mid_rst_oen", 64'(oen), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data_in", 64'(data_in), 64'h00);
        chk("mid_rst_ok_cnt", 64'(frame_ok_cnt), 64'd0);
        chk("mid_rst_regs", 64'(regs_flat[63:0]), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_bytes_after_rst", 64'(tx_q.size()), 64'd2);
        chk("idle_after_rst", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
